// File: rtl/lmsm_pkg.sv
// Shared types and default widths for the LM/SM multi-access sequencer.
package lmsm_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned NREG_DEF   = 8;
    localparam int unsigned IDX_W      = 3;

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Memory and register-file side bus of the sequencer; master = sequencer.
interface lmsm_sequencer_if
    import lmsm_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write_n;
    logic              mem_read_n;
    logic [DATA_W-1:0] mem_rdata;
    reg_idx_t          rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    reg_idx_t          rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;

    modport master (
        output mem_addr, mem_wdata, mem_write_n, mem_read_n,
        output rf_raddr, rf_waddr, rf_wdata, rf_we,
        input  mem_rdata, rf_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_write_n, mem_read_n,
        input  rf_raddr, rf_waddr, rf_wdata, rf_we,
        output mem_rdata, rf_rdata
    );

endinterface

// File: rtl/lmsm_sequencer_prio_enc8.sv
// Lowest-set-bit priority encoder for an 8-bit register list.
module prio_enc8
    import lmsm_pkg::*;
(
    input  logic [7:0] vec,
    output reg_idx_t   idx,
    output logic       valid
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = reg_idx_t'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: one memory access per listed register on consecutive cycles,
// with pipelined register-file writeback for loads.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREG   = NREG_DEF
)(
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_list,
    output logic              busy,
    output logic              done,
    lmsm_sequencer_if.master  bus
);

    state_t            state_q, state_d;
    logic [NREG-1:0]   remain_q, remain_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              store_q, store_d;
    reg_idx_t          cur_idx_q, cur_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              st_cyc_q, st_cyc_d;
    logic              rf_we_q, rf_we_d;
    reg_idx_t          rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [NREG-1:0]   enc_vec;
    reg_idx_t          enc_idx;
    logic              enc_valid;
    logic              issue;
    logic              issue_store;
    logic [ADDR_W-1:0] issue_addr;

    // In IDLE the encoder looks at the incoming list, otherwise at what remains.
    assign enc_vec = (state_q == IDLE) ? reg_list : remain_q;

    prio_enc8 u_enc (
        .vec   (enc_vec),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        store_d     = store_q;
        cur_idx_d   = cur_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        st_cyc_d    = 1'b0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        issue       = 1'b0;
        issue_store = store_q;
        issue_addr  = ptr_q;

        // A load access this cycle retires into the register file next cycle.
        if (state_q == ACCESS && !store_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = cur_idx_q;
            rf_wdata_d = bus.mem_rdata;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    store_d     = is_store;
                    issue_store = is_store;
                    issue_addr  = base_addr;
                    if (enc_valid) begin
                        issue   = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (enc_valid) begin
                    issue = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            cur_idx_d  = enc_idx;
            remain_d   = enc_vec & ~(NREG'(1) << enc_idx);
            mem_addr_d = issue_addr;
            ptr_d      = issue_addr + ADDR_W'(1);
            wr_n_d     = ~issue_store;
            rd_n_d     = issue_store;
            st_cyc_d   = issue_store;
        end
    end

    always_ff @(posedge clk) begin
        if (!proc_rst) begin
            state_q    <= IDLE;
            remain_q   <= '0;
            ptr_q      <= '0;
            mem_addr_q <= '0;
            store_q    <= 1'b0;
            cur_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            st_cyc_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            ptr_q      <= ptr_d;
            mem_addr_q <= mem_addr_d;
            store_q    <= store_d;
            cur_idx_q  <= cur_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            st_cyc_q   <= st_cyc_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign bus.mem_addr    = mem_addr_q;
    // Store data flows straight from the register-file read port.
    assign bus.mem_wdata   = st_cyc_q ? bus.rf_rdata : '0;
    // Strobes forced inactive during reset so the memory preload is not disturbed.
    assign bus.mem_write_n = wr_n_q | ~proc_rst;
    assign bus.mem_read_n  = rd_n_q | ~proc_rst;
    assign bus.rf_raddr    = cur_idx_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.rf_we       = rf_we_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: memory/register-file models plus a
// per-cycle expected-trace scoreboard.
module tb_lmsm_sequencer;
    import lmsm_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_n;
        logic        wr_n;
        logic        acc;
        logic        we;
        logic [5:0]  addr;
        logic [15:0] mwdata;
        logic [2:0]  waddr;
        logic [15:0] wdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       proc_rst = 1'b0;
    logic       start = 1'b0;
    logic       is_store = 1'b0;
    logic [5:0] base_addr = '0;
    logic [7:0] reg_list = '0;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    exp_t sbq[$];

    lmsm_sequencer_if bus ();

    lmsm_sequencer dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .reg_list  (reg_list),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Memory model: acts on the negedge; poke port used for preloading.
    logic [15:0] mem [64];
    logic [15:0] rf  [8];
    logic [15:0] rdata_q = '0;
    logic        pk_m_en = 1'b0;
    logic [5:0]  pk_m_a = '0;
    logic [15:0] pk_m_d = '0;
    logic        pk_r_en = 1'b0;
    logic [2:0]  pk_r_a = '0;
    logic [15:0] pk_r_d = '0;

    always @(negedge clk) begin
        if (pk_m_en) mem[pk_m_a] <= pk_m_d;
        else if (!bus.mem_write_n) mem[bus.mem_addr] <= bus.mem_wdata;
        if (!bus.mem_read_n) rdata_q <= mem[bus.mem_addr];
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(posedge clk) begin
        if (pk_r_en) rf[pk_r_a] <= pk_r_d;
        else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.rf_rdata  = rf[bus.rf_raddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_mem(input logic [5:0] a, input logic [15:0] d);
        pk_m_en = 1'b1; pk_m_a = a; pk_m_d = d;
        @(negedge clk);
        #1;
        pk_m_en = 1'b0;
    endtask

    task automatic poke_rf(input logic [2:0] a, input logic [15:0] d);
        pk_r_en = 1'b1; pk_r_a = a; pk_r_d = d;
        @(posedge clk);
        #1;
        pk_r_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Builds the expected per-cycle trace for cycles 1..n+1 of one operation.
    task automatic push_op(input logic st, input logic [5:0] base, input logic [7:0] list);
        logic [2:0] idx_q[$];
        logic [5:0] ad_q[$];
        logic [5:0] p;
        exp_t       e;
        int         n;
        p = base;
        for (int i = 0; i < 8; i++) begin
            if (list[i]) begin
                idx_q.push_back(3'(i));
                ad_q.push_back(p);
                p = p + 6'd1;
            end
        end
        n = idx_q.size();
        for (int c = 1; c <= n + 1; c++) begin
            e = '0;
            e.busy = 1'b1;
            e.done = (c == n + 1);
            e.rd_n = 1'b1;
            e.wr_n = 1'b1;
            if (c <= n) begin
                e.acc  = 1'b1;
                e.addr = ad_q[c-1];
                if (st) begin
                    e.wr_n   = 1'b0;
                    e.mwdata = rf[idx_q[c-1]];
                end else begin
                    e.rd_n = 1'b0;
                end
            end
            if (!st && c >= 2) begin
                e.we    = 1'b1;
                e.waddr = idx_q[c-2];
                e.wdata = mem[ad_q[c-2]];
            end
            sbq.push_back(e);
        end
    endtask

    task automatic check_cycle(input int c);
        exp_t e;
        if (sbq.size() == 0) begin
            chk($sformatf("sb_empty_c%0d", c), 32'(1), 32'(0));
            return;
        end
        e = sbq.pop_front();
        chk($sformatf("busy_c%0d", c),  32'(busy),            32'(e.busy));
        chk($sformatf("done_c%0d", c),  32'(done),            32'(e.done));
        chk($sformatf("rd_n_c%0d", c),  32'(bus.mem_read_n),  32'(e.rd_n));
        chk($sformatf("wr_n_c%0d", c),  32'(bus.mem_write_n), 32'(e.wr_n));
        chk($sformatf("mwd_c%0d", c),   32'(bus.mem_wdata),   32'(e.mwdata));
        chk($sformatf("rf_we_c%0d", c), 32'(bus.rf_we),       32'(e.we));
        if (e.acc) chk($sformatf("addr_c%0d", c), 32'(bus.mem_addr), 32'(e.addr));
        if (e.we) begin
            chk($sformatf("waddr_c%0d", c), 32'(bus.rf_waddr), 32'(e.waddr));
            chk($sformatf("wdata_c%0d", c), 32'(bus.rf_wdata), 32'(e.wdata));
        end
    endtask

    // Runs one operation; a nonzero stray injects a start pulse in that cycle.
    task automatic run_op(input logic st, input logic [5:0] base, input logic [7:0] list, input int stray);
        int n;
        n = $countones(list);
        push_op(st, base, list);
        start = 1'b1; is_store = st; base_addr = base; reg_list = list;
        tick();
        start = 1'b0; is_store = ~st; base_addr = ~base; reg_list = ~list;
        for (int c = 1; c <= n + 1; c++) begin
            check_cycle(c);
            if (c == stray) begin
                start = 1'b1; is_store = 1'b1; reg_list = 8'hFF;
            end
            tick();
            start = 1'b0;
        end
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_done", 32'(done), 32'(0));
        chk("idle_rd_n", 32'(bus.mem_read_n), 32'(1));
        chk("idle_wr_n", 32'(bus.mem_write_n), 32'(1));
    endtask

    initial begin
        int d0;

        // Reset state, with a start attempt that reset must override.
        start = 1'b1; reg_list = 8'hFF;
        tick();
        tick();
        start = 1'b0; reg_list = '0;
        chk("rst_busy",  32'(busy), 32'(0));
        chk("rst_done",  32'(done), 32'(0));
        chk("rst_addr",  32'(bus.mem_addr), 32'(0));
        chk("rst_mwd",   32'(bus.mem_wdata), 32'(0));
        chk("rst_wr_n",  32'(bus.mem_write_n), 32'(1));
        chk("rst_rd_n",  32'(bus.mem_read_n), 32'(1));
        chk("rst_raddr", 32'(bus.rf_raddr), 32'(0));
        chk("rst_waddr", 32'(bus.rf_waddr), 32'(0));
        chk("rst_wdata", 32'(bus.rf_wdata), 32'(0));
        chk("rst_we",    32'(bus.rf_we), 32'(0));

        // Preload memory and register file while held in reset.
        poke_rf(3'd0, 16'h1111);
        poke_rf(3'd2, 16'h2222);
        poke_mem(6'd20, 16'h0000);
        poke_mem(6'd21, 16'h0000);
        poke_mem(6'd23, 16'h0003);
        poke_mem(6'd24, 16'h0005);
        poke_mem(6'd62, 16'hA03E);
        poke_mem(6'd63, 16'hA03F);
        for (int i = 0; i < 6; i++) poke_mem(6'(i), 16'hA000 + 16'(i));
        for (int i = 40; i < 48; i++) poke_mem(6'(i), 16'hC000 + 16'(i));
        chk("rst_hold_busy", 32'(busy), 32'(0));
        tick();
        proc_rst = 1'b1;
        tick();

        // SM R0,R2 to 20,21.
        run_op(1'b1, 6'd20, 8'b0000_0101, 0);
        chk("sm_mem20", 32'(mem[20]), 32'h1111);
        chk("sm_mem21", 32'(mem[21]), 32'h2222);

        // LM R1,R7 from 23,24.
        run_op(1'b0, 6'd23, 8'b1000_0010, 0);
        chk("lm_r1", 32'(rf[1]), 32'h0003);
        chk("lm_r7", 32'(rf[7]), 32'h0005);

        // LM all registers across the 63->0 wrap.
        run_op(1'b0, 6'd62, 8'hFF, 0);
        chk("wrap_r0", 32'(rf[0]), 32'hA03E);
        chk("wrap_r1", 32'(rf[1]), 32'hA03F);
        for (int i = 2; i < 8; i++)
            chk($sformatf("wrap_r%0d", i), 32'(rf[i]), 32'hA000 + 32'(i - 2));

        // Empty list.
        d0 = done_cnt;
        run_op(1'b0, 6'd10, 8'h00, 0);
        chk("empty_done_cnt", 32'(done_cnt - d0), 32'(1));

        // Reset in cycle 2 of an 8-register store.
        d0 = done_cnt;
        start = 1'b1; is_store = 1'b1; base_addr = 6'd40; reg_list = 8'hFF;
        tick();
        start = 1'b0;
        chk("mr_c1_wr_n", 32'(bus.mem_write_n), 32'(0));
        chk("mr_c1_addr", 32'(bus.mem_addr), 32'(40));
        tick();
        proc_rst = 1'b0;
        #1;
        chk("mr_c2_wr_n", 32'(bus.mem_write_n), 32'(1));
        chk("mr_c2_rd_n", 32'(bus.mem_read_n), 32'(1));
        tick();
        proc_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("mr_idle_busy%0d", c), 32'(busy), 32'(0));
            chk($sformatf("mr_idle_we%0d", c), 32'(bus.rf_we), 32'(0));
            chk($sformatf("mr_idle_wr_n%0d", c), 32'(bus.mem_write_n), 32'(1));
            tick();
        end
        chk("mr_no_done", 32'(done_cnt - d0), 32'(0));
        chk("mr_mem40", 32'(mem[40]), 32'hA03E);
        for (int i = 41; i < 48; i++)
            chk($sformatf("mr_mem%0d", i), 32'(mem[i]), 32'hC000 + 32'(i));

        // Start pulsed while busy must be ignored.
        d0 = done_cnt;
        run_op(1'b0, 6'd0, 8'b0011_1100, 3);
        tick();
        tick();
        chk("stray_busy", 32'(busy), 32'(0));
        chk("stray_done_cnt", 32'(done_cnt - d0), 32'(1));
        chk("stray_r2", 32'(rf[2]), 32'hA000);
        chk("stray_r5", 32'(rf[5]), 32'hA003);
        chk("sb_drained", 32'(sbq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
